// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Used by seq_div_16_8 and its single-step subtractor seq_div_step.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    // Quotient reported for a zero divisor: all ones over w bits.
    function automatic logic [63:0] dz_quotient(input int w);
        logic [63:0] r;
        if (w >= 64) begin
            r = '1;
        end else begin
            r = (64'd1 << w) - 64'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in a dividend bit and conditionally
// subtract the divisor. Kept separate so an approximate subtractor can drop in.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic          q_o
);

    // The shifted partial remainder needs VW+1 bits; after a
    // conditional subtract it is below the divisor and fits VW bits.
    logic [VW:0]   part;
    logic [VW-1:0] diff;

    // Compare-and-subtract for a single quotient bit.
    always_comb begin
        part  = {rem_i, bit_i};
        diff  = part[VW-1:0] - divisor_i;
        q_o   = (part >= {1'b0, divisor_i});
        rem_o = q_o ? diff : part[VW-1:0];
    end

endmodule

// File: rtl/seq_div_16_8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV_BACK_TO_BACK_EN lets DONE accept new operands.
module seq_div_16_8
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [63:0] DZ_FULL = dz_quotient(DW);
    localparam logic [DW-1:0] DZ_QUOT = DZ_FULL[DW-1:0];
    localparam logic [CW-1:0] CNT_TOP = CW'(DW - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_q, dz_d;

    logic          accept;
    logic [VW-1:0] step_rem;
    logic          step_q;

    seq_div_step #(
        .VW(VW)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (dvd_q[cnt_q]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

`ifdef SEQ_DIV_BACK_TO_BACK_EN
    assign in_ready = (state_q == IDLE)
                    | ((state_q == DONE) & out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

    // Next-state: operand load, per-bit step, result handshake.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        if (accept) begin
            dvd_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_TOP;
            if (divisor == '0) begin
                state_d = DONE;
                quot_d  = DZ_QUOT;
                rem_d   = dividend[VW-1:0];
                dz_d    = 1'b1;
            end else begin
                state_d = CALC;
                quot_d  = '0;
                rem_d   = '0;
                dz_d    = 1'b0;
            end
        end else begin
            case (state_q)
                CALC: begin
                    rem_d         = step_rem;
                    quot_d[cnt_q] = step_q;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_div_16_8.sv
// Directed self-checking bench for seq_div_16_8.
// Period expectation follows SEQ_DIV_BACK_TO_BACK_EN.
module tb_seq_div_16_8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_chk;
    int n_fail;

`ifdef SEQ_DIV_BACK_TO_BACK_EN
    localparam int PERIOD = 17;
`else
    localparam int PERIOD = 18;
`endif

    seq_div_16_8 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 16'hBEEF;
        divisor  = 8'h5A;
    endtask

    task automatic run(input string tag, input logic [15:0] a,
                       input logic [7:0] b, input logic [15:0] eq,
                       input logic [7:0] er, input logic edz,
                       input int elat);
        int lat;
        start(a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dz"}, 32'(div_zero), 32'(edz));
    endtask

    logic [15:0] tv_a [10];
    logic [7:0]  tv_b [10];
    logic [15:0] tv_q [10];
    logic [7:0]  tv_r [10];

    initial begin
        tv_a = '{16'd65535, 16'd12345, 16'd255, 16'd0, 16'd60000,
                 16'd9999, 16'd4096, 16'd50001, 16'd777, 16'd32768};
        tv_b = '{8'd255, 8'd100, 8'd16, 8'd9, 8'd7,
                 8'd99, 8'd128, 8'd250, 8'd200, 8'd3};
        tv_q = '{16'd257, 16'd123, 16'd15, 16'd0, 16'd8571,
                 16'd101, 16'd32, 16'd200, 16'd3, 16'd10922};
        tv_r = '{8'd0, 8'd45, 8'd15, 8'd0, 8'd3,
                 8'd0, 8'd0, 8'd1, 8'd177, 8'd2};

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_iready", 32'(in_ready), 1);
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_dz", 32'(div_zero), 0);

        run("t1", 16'd56100, 8'd220, 16'd255, 8'd0, 1'b0, 17);
        tick();
        chk("t1_idle", 32'(out_valid), 0);

        run("t2a", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        tick();
        run("t2b", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
        tick();

        run("t3", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1);
        tick();

        out_ready = 1'b0;
        run("t4", 16'd40000, 8'd255, 16'd156, 8'd220, 1'b0, 17);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 16'd1;
            divisor  = 8'd1;
            tick();
            chk("t4_hold_ov", 32'(out_valid), 1);
            chk("t4_hold_ir", 32'(in_ready), 0);
            chk("t4_hold_q", 32'(quotient), 156);
            chk("t4_hold_r", 32'(remainder), 220);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_release_ov", 32'(out_valid), 0);
        chk("t4_release_ir", 32'(in_ready), 1);

        start(16'd50000, 8'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_calc_ir", 32'(in_ready), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_ov", 32'(out_valid), 0);
        chk("t5_rst_ir", 32'(in_ready), 1);
        chk("t5_rst_q", 32'(quotient), 0);
        run("t5", 16'd50000, 8'd3, 16'd16666, 8'd2, 1'b0, 17);
        tick();

        begin
            int cyc;
            int nacc;
            int nres;
            int last;
            logic acc;
            cyc  = 0;
            nacc = 0;
            nres = 0;
            last = -1;
            out_ready = 1'b1;
            while (nres < 10 && cyc < 400) begin
                if (nacc < 10) begin
                    in_valid = 1'b1;
                    dividend = tv_a[nacc];
                    divisor  = tv_b[nacc];
                end else begin
                    in_valid = 1'b0;
                end
                acc = in_valid && in_ready;
                tick();
                cyc++;
                if (acc) nacc++;
                if (out_valid) begin
                    chk("t6_q", 32'(quotient), 32'(tv_q[nres]));
                    chk("t6_r", 32'(remainder), 32'(tv_r[nres]));
                    if (last >= 0) chk("t6_period", cyc - last, PERIOD);
                    last = cyc;
                    nres++;
                end
            end
            in_valid = 1'b0;
            chk("t6_count", nres, 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
